stopwatch_ctrl: RTL
===================

// Module: stopwatch_ctrl
// PURPOSE
//  Mode controller and timekeeper for the stopwatch; sits between the debouncer and the display driver.
//  Converts debounced button levels into single-cycle events and runs a RUN/PAUSED/ADJUST FSM.
//  Maintains the MM:SS count (00:00..59:59) from an internal prescaled 1 Hz tick.
//  In adjust mode, steps the selected field at ADJ_DIV rate and drives a blink flag for the display.
// PARAMETERS
//  TICK_DIV  100_000_000  clk cycles per 1 Hz run tick (>=2)
//  ADJ_DIV   50_000_000   clk cycles per adjust step / blink toggle (>=2)
// PORTS
//  clk        in   1  system clock; all logic on posedge
//  rst_n      in   1  asynchronous, active-low reset
//  rst_lvl    in   1  debounced reset-button level
//  pause_lvl  in   1  debounced pause-button level
//  adj        in   1  adjust-switch level (1 = adjust mode)
//  sel        in   1  adjust field select: 0 = minutes, 1 = seconds
//  minutes    out  6  current minutes, 0..59
//  seconds    out  6  current seconds, 0..59
//  running    out  1  1 while in RUN
//  blink      out  1  blink phase for the selected field; 0 outside ADJUST
// BEHAVIOUR
//  Reset (rst_n=0, async): state=PAUSED; minutes=0, seconds=0, running=0, blink=0.
//   Both prescalers = 0; edge registers = 0.
//  Edge detect:
//   - rst_p = rst_lvl & ~rst_q, and likewise pause_p; rst_q/pause_q are registered copies of the levels.
//   - A held level yields exactly one pulse.
//   - The FSM and outputs update on the same edge at which rst_p/pause_p is 1 (1-cycle latency from sampled rise).
//  FSM priority, highest first:
//   (1) rst_p: minutes=seconds=0; tick prescaler cleared.
//       RUN/PAUSED->PAUSED; ADJUST stays ADJUST.
//   (2) adj=1 and state!=ADJUST -> ADJUST.
//       adj=0 and state==ADJUST -> PAUSED.
//   (3) pause_p: RUN<->PAUSED toggle. Ignored in ADJUST.
//   (4) Tick handling, below.
//  Simultaneous rst_p and pause_p: rst_p wins; the pause event is discarded.
//  Run tick:
//   - Tick prescaler counts 0..TICK_DIV-1 only in RUN and holds its value in PAUSED, so the fractional second is kept across pauses.
//   - It is cleared in ADJUST and by rst_p.
//   - Tick fires on the cycle the count is TICK_DIV-1; the count then wraps to 0.
//   - On tick, seconds+1. At 59, seconds->0 and minutes+1.
//   - 59:59 -> 00:00 wraps silently.
//  Adjust tick:
//   - Adjust prescaler free-runs 0..ADJ_DIV-1 only in ADJUST; it is cleared when leaving ADJUST.
//   - On adjust tick: the field chosen by sel increments mod 60, with no carry into the other field, and blink toggles.
//   - sel change takes effect at the next adjust tick. blink is forced to 0 on the edge ADJUST is left.
//  rst_p in the same cycle as an adjust tick: the clear wins and the field stays 0.
//  running = (state==RUN). All outputs are registered with no combinational input->output path.
//  rst_n asserted mid-operation aborts everything immediately to the reset values.
// STRUCTURE
//  stopwatch_pkg:
//   - state enum {PAUSED, RUN, ADJUST} as 2-bit localparams
//   - MAX_FIELD = 59
//   - FIELD_W = 6
//  Sub-module tick_gen #(DIV):
//   - ports clk, rst_n, en, clr, tick
//   - en=0 holds the count; clr dominates en
//   - instantiated twice (run tick, adjust tick)
//  Top holds the edge registers, FSM, MM:SS registers and blink flop.
// TESTING
//  All tests use TICK_DIV=4 and ADJ_DIV=2.
//  T1 Reset: rst_n low mid-RUN at 12:34 -> 00:00, running=0, blink=0 immediately.
//     After release, 20 cycles idle -> values unchanged.
//  T2 Start/count/wrap: pause_lvl 0->1 -> running=1 one cycle after sampled rise.
//     240 cycles later -> 01:00. Preload 59:59, 4 cycles -> 00:00.
//  T3 Held button: pause_lvl held high for 50 cycles -> exactly one RUN toggle.
//     Release, then rise again -> PAUSED, with the prescaler count preserved.
//  T4 Adjust:
//     - From PAUSED at 00:58, adj=1 and sel=1, 4 cycles -> 00:00 with minutes=0 (no carry); blink toggled twice.
//     - sel=0 -> minutes step.
//     - adj=0 -> PAUSED with blink=0.
//  T5 Collision: in RUN at 03:07, rst_lvl and pause_lvl rise on the same cycle -> 00:00, running=0, no toggle.
//  T6 Pause in adjust: pause_p during ADJUST -> ignored. adj=0 -> PAUSED. Then pause_p -> RUN.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch mode controller.
package stopwatch_pkg;

  localparam int FIELD_W = 6;
  localparam logic [FIELD_W-1:0] MAX_FIELD = 6'd59;

  typedef enum logic [1:0] {
    ST_PAUSED = 2'd0,
    ST_RUN    = 2'd1,
    ST_ADJUST = 2'd2
  } state_e;

  // Wraps a minutes/seconds field 59 -> 0.
  function automatic logic [FIELD_W-1:0] inc_mod60(input logic [FIELD_W-1:0] v);
    return (v == MAX_FIELD) ? '0 : v + 6'd1;
  endfunction

endpackage

// File: rtl/stopwatch_ctrl_tick_gen.sv
// Prescaler: counts 0..DIV-1 while enabled and pulses tick on the last count.
module tick_gen #(
  parameter int unsigned DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int W = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] count_q, count_d;

  // clr dominates en; a disabled prescaler holds its count.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      count_d = (count_q == LAST) ? '0 : count_q + 1'b1;
    end
  end

  assign tick = en & ~clr & (count_q == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch mode controller: button edge detect, RUN/PAUSED/ADJUST FSM and MM:SS timekeeping.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int unsigned TICK_DIV = 100_000_000,
  parameter int unsigned ADJ_DIV  = 50_000_000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               rst_lvl,
  input  logic               pause_lvl,
  input  logic               adj,
  input  logic               sel,
  output logic [FIELD_W-1:0] minutes,
  output logic [FIELD_W-1:0] seconds,
  output logic               running,
  output logic               blink
);

  state_e             state_q, state_d;
  logic [FIELD_W-1:0] min_q, min_d;
  logic [FIELD_W-1:0] sec_q, sec_d;
  logic               blink_q, blink_d;
  logic               rst_q, pause_q;
  logic               rst_p, pause_p;
  logic               run_en, run_clr, run_tick;
  logic               adj_en, adj_clr, adj_tick;

  assign rst_p   = rst_lvl & ~rst_q;
  assign pause_p = pause_lvl & ~pause_q;

  // The run prescaler only advances on cycles where the tick would actually be
  // applied, so a pause or mode change never drops a pending second.
  assign run_en  = (state_q == ST_RUN) & ~adj & ~pause_p;
  assign run_clr = rst_p | (state_q == ST_ADJUST);

  assign adj_en  = (state_q == ST_ADJUST) & adj;
  assign adj_clr = (state_q != ST_ADJUST) | ~adj;

  tick_gen #(.DIV(TICK_DIV)) u_run_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (run_en),
    .clr   (run_clr),
    .tick  (run_tick)
  );

  tick_gen #(.DIV(ADJ_DIV)) u_adj_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (adj_en),
    .clr   (adj_clr),
    .tick  (adj_tick)
  );

  // Priority chain: button reset, mode switch, pause toggle, then ticks.
  always_comb begin
    state_d = state_q;
    min_d   = min_q;
    sec_d   = sec_q;
    blink_d = blink_q;
    if (rst_p) begin
      min_d = '0;
      sec_d = '0;
      if (state_q != ST_ADJUST) begin
        state_d = ST_PAUSED;
      end
    end else if (adj && (state_q != ST_ADJUST)) begin
      state_d = ST_ADJUST;
    end else if (!adj && (state_q == ST_ADJUST)) begin
      state_d = ST_PAUSED;
      blink_d = 1'b0;
    end else if (pause_p && (state_q != ST_ADJUST)) begin
      state_d = (state_q == ST_RUN) ? ST_PAUSED : ST_RUN;
    end else if (run_tick) begin
      sec_d = inc_mod60(sec_q);
      if (sec_q == MAX_FIELD) begin
        min_d = inc_mod60(min_q);
      end
    end else if (adj_tick) begin
      blink_d = ~blink_q;
      if (sel) begin
        sec_d = inc_mod60(sec_q);
      end else begin
        min_d = inc_mod60(min_q);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_PAUSED;
      min_q   <= '0;
      sec_q   <= '0;
      blink_q <= 1'b0;
      rst_q   <= 1'b0;
      pause_q <= 1'b0;
    end else begin
      state_q <= state_d;
      min_q   <= min_d;
      sec_q   <= sec_d;
      blink_q <= blink_d;
      rst_q   <= rst_lvl;
      pause_q <= pause_lvl;
    end
  end

  assign minutes = min_q;
  assign seconds = sec_q;
  assign running = (state_q == ST_RUN);
  assign blink   = blink_q;

endmodule
